uart_alu_intf: RTL and testbench

//  Sits between UART_RX/UART_TX and host. Collects three received bytes (operand A,

---
 rtl/uart_alu_intf_if.sv | 38 +++
 rtl/uart_alu_intf.sv | 164 ++++++++++++++++
 tb/tb_uart_alu_intf.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_intf_if.sv
// ---------------------------------------------------------------------------
// uart_alu_intf_if
// Groups the UART-side handshake and data signals of the UART ALU glue block.
// Signal names are seen from the ALU block's point of view (i_ = into it).
//   i_rx_done    1-cycle strobe from UART_RX: received byte is valid
//   i_rx_data    received byte
//   i_rx_parity  received parity bit
//   i_tx_done    1-cycle strobe from UART_TX: frame finished
//   o_tx_signal  1-cycle send strobe to UART_TX
//   o_tx_data    result byte to UART_TX
//   o_tx_parity  even parity of o_tx_data
//   o_busy       command executing or waiting for TX
//   o_error      1-cycle error pulse
// Modports: slave = ALU block, master = UART/host side driving it.
// ---------------------------------------------------------------------------
interface uart_alu_intf_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_rx_done;
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_parity;
    logic                  i_tx_done;
    logic                  o_tx_signal;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_parity;
    logic                  o_busy;
    logic                  o_error;

    modport slave (
        input  i_rx_done, i_rx_data, i_rx_parity, i_tx_done,
        output o_tx_signal, o_tx_data, o_tx_parity, o_busy, o_error
    );

    modport master (
        output i_rx_done, i_rx_data, i_rx_parity, i_tx_done,
        input  o_tx_signal, o_tx_data, o_tx_parity, o_busy, o_error
    );
endinterface

// File: rtl/uart_alu_intf.sv
// ---------------------------------------------------------------------------
// uart_alu_intf
// Glue between UART_RX/UART_TX and an internal ALU. Collects operand A,
// operand B and an opcode byte, executes one operation, hands the result to
// UART_TX with a one-cycle strobe and waits for TX completion before taking
// the next command.
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      uart_alu_intf_if.slave (rx strobe/data/parity, tx done in;
//            tx strobe/data/parity, busy, error out)
// Optional build macro:
//   UART_INTF_PARITY_CHECK_EN  drop received bytes with a parity fault and
//                              pulse o_error; otherwise rx parity is ignored.
// ---------------------------------------------------------------------------
module uart_alu_intf #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    uart_alu_intf_if.slave        bus
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(6'b100000);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(6'b100010);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(6'b100100);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(6'b100101);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(6'b100110);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOR = OPCODE_WIDTH'(6'b100111);
    localparam logic [OPCODE_WIDTH-1:0] OP_SRA = OPCODE_WIDTH'(6'b000011);
    localparam logic [OPCODE_WIDTH-1:0] OP_SRL = OPCODE_WIDTH'(6'b000010);

    typedef enum logic [2:0] {
        S_OP_A,
        S_OP_B,
        S_OPCODE,
        S_EXEC,
        S_WAIT_TX
    } state_t;

    state_t                  r_state;
    logic [DATA_WIDTH-1:0]   r_op_a;
    logic [DATA_WIDTH-1:0]   r_op_b;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_tx_parity;
    logic                    r_tx_signal;
    logic                    r_busy;
    logic                    r_error;

    logic [DATA_WIDTH-1:0]   w_result;
    logic [OPCODE_WIDTH-1:0] w_rx_opcode;
    logic                    w_rx_ok;

    function automatic logic is_valid_op(input logic [OPCODE_WIDTH-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign w_rx_opcode = bus.i_rx_data[OPCODE_WIDTH-1:0];

`ifdef UART_INTF_PARITY_CHECK_EN
    assign w_rx_ok = (bus.i_rx_parity == ^bus.i_rx_data);
`else
    logic w_unused_parity;
    assign w_unused_parity = bus.i_rx_parity;
    assign w_rx_ok         = 1'b1;
`endif

    // Shift amounts at or beyond DATA_WIDTH saturate naturally: all-sign / zero.
    always_comb begin
        w_result = '0;
        case (r_opcode)
            OP_ADD:  w_result = r_op_a + r_op_b;
            OP_SUB:  w_result = r_op_a - r_op_b;
            OP_AND:  w_result = r_op_a & r_op_b;
            OP_OR:   w_result = r_op_a | r_op_b;
            OP_XOR:  w_result = r_op_a ^ r_op_b;
            OP_NOR:  w_result = ~(r_op_a | r_op_b);
            OP_SRA:  w_result = $signed(r_op_a) >>> r_op_b;
            OP_SRL:  w_result = r_op_a >> r_op_b;
            default: w_result = '0;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_OP_A;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_opcode    <= '0;
            r_tx_data   <= '0;
            r_tx_parity <= 1'b0;
            r_tx_signal <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_error <= 1'b0;
            case (r_state)
                S_OP_A: begin
                    if (bus.i_rx_done) begin
                        if (w_rx_ok) begin
                            r_op_a  <= bus.i_rx_data;
                            r_state <= S_OP_B;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_OP_B: begin
                    if (bus.i_rx_done) begin
                        if (w_rx_ok) begin
                            r_op_b  <= bus.i_rx_data;
                            r_state <= S_OPCODE;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_OPCODE: begin
                    if (bus.i_rx_done) begin
                        if (w_rx_ok) begin
                            r_opcode <= w_rx_opcode;
                            r_busy   <= 1'b1;
                            // Flag a bad opcode now so the pulse lines up with S_EXEC.
                            r_error  <= !is_valid_op(w_rx_opcode);
                            r_state  <= S_EXEC;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    r_tx_data   <= w_result;
                    r_tx_parity <= ^w_result;
                    r_tx_signal <= 1'b1;
                    r_state     <= S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    r_tx_signal <= 1'b0;
                    // Any rx byte arriving here is dropped.
                    if (bus.i_tx_done) begin
                        r_busy  <= 1'b0;
                        r_state <= S_OP_A;
                    end
                end
                default: begin
                    r_state <= S_OP_A;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_tx_signal = r_tx_signal;
    assign bus.o_tx_data   = r_tx_data;
    assign bus.o_tx_parity = r_tx_parity;
    assign bus.o_busy      = r_busy;
    assign bus.o_error     = r_error;

endmodule

// File: tb/tb_uart_alu_intf.sv
// ---------------------------------------------------------------------------
// tb_uart_alu_intf
// Directed bench for uart_alu_intf: drives bytes on the falling edge, checks
// outputs on the falling edge against hand-computed results.
// ---------------------------------------------------------------------------
module tb_uart_alu_intf;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_alu_intf_if #(.DATA_WIDTH(8)) bus ();

    uart_alu_intf #(
        .DATA_WIDTH   (8),
        .OPCODE_WIDTH (6)
    ) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic p);
        @(negedge clk);
        bus.i_rx_data   = d;
        bus.i_rx_parity = p;
        bus.i_rx_done   = 1'b1;
        @(negedge clk);
        bus.i_rx_done   = 1'b0;
    endtask

    task automatic pulse_tx_done();
        @(negedge clk);
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
    endtask

    // Sends A, B, opcode and checks timing up to the end of the send strobe.
    task automatic run_cmd(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp, input logic exp_err);
        send_byte(a, ^a);
        send_byte(b, ^b);
        send_byte(op, ^op);
        check({tag, " exec busy"}, bus.o_busy, 1);
        check({tag, " exec strobe"}, bus.o_tx_signal, 0);
        check({tag, " exec error"}, bus.o_error, exp_err);
        @(negedge clk);
        check({tag, " strobe"}, bus.o_tx_signal, 1);
        check({tag, " data"}, bus.o_tx_data, exp);
        check({tag, " parity"}, bus.o_tx_parity, ^exp);
        check({tag, " strobe error"}, bus.o_error, 0);
        @(negedge clk);
        check({tag, " strobe low"}, bus.o_tx_signal, 0);
        check({tag, " wait busy"}, bus.o_busy, 1);
        check({tag, " data hold"}, bus.o_tx_data, exp);
    endtask

    task automatic finish_tx(input string tag);
        pulse_tx_done();
        check({tag, " idle busy"}, bus.o_busy, 0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b1;
        bus.i_rx_done   = 1'b0;
        bus.i_rx_data   = '0;
        bus.i_rx_parity = 1'b0;
        bus.i_tx_done   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset tx_data", bus.o_tx_data, 0);
        check("reset tx_signal", bus.o_tx_signal, 0);
        check("reset busy", bus.o_busy, 0);
        check("reset error", bus.o_error, 0);
        rst = 1'b0;

        // tx_done while idle is ignored
        pulse_tx_done();
        check("stray tx_done busy", bus.o_busy, 0);

        // Basic ADD
        run_cmd("add", 8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
        check("add parity const", bus.o_tx_parity, 1);
        finish_tx("add");

        run_cmd("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
        finish_tx("sub");
        run_cmd("sra", 8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
        finish_tx("sra");
        run_cmd("srl", 8'h80, 8'h02, 8'h02, 8'h20, 1'b0);
        finish_tx("srl");
        run_cmd("nor", 8'h0F, 8'hF0, 8'h27, 8'h00, 1'b0);
        finish_tx("nor");
        run_cmd("or", 8'h0C, 8'h03, 8'h25, 8'h0F, 1'b0);
        finish_tx("or");
        run_cmd("xor", 8'hFF, 8'h0F, 8'h26, 8'hF0, 1'b0);
        finish_tx("xor");
        run_cmd("sra big", 8'h80, 8'h09, 8'h03, 8'hFF, 1'b0);
        finish_tx("sra big");
        run_cmd("srl big", 8'hFF, 8'h08, 8'h02, 8'h00, 1'b0);
        finish_tx("srl big");
        // Opcode upper bits ignored: 0xE0 decodes as ADD
        run_cmd("add hi", 8'h10, 8'h20, 8'hE0, 8'h30, 1'b0);
        finish_tx("add hi");

        // Invalid opcode: zero result, error pulse, strobe still issued
        run_cmd("invalid", 8'h11, 8'h22, 8'h3F, 8'h00, 1'b1);
        finish_tx("invalid");

        // Byte during WAIT_TX dropped
        run_cmd("pre drop", 8'h01, 8'h02, 8'h20, 8'h03, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("drop busy", bus.o_busy, 1);
        check("drop error", bus.o_error, 0);
        check("drop data", bus.o_tx_data, 8'h03);
        finish_tx("drop");
        run_cmd("after drop", 8'h01, 8'h01, 8'h20, 8'h02, 1'b0);

        // rx_done together with tx_done: byte dropped, back to idle
        @(negedge clk);
        bus.i_rx_data   = 8'h77;
        bus.i_rx_parity = ^bus.i_rx_data;
        bus.i_rx_done   = 1'b1;
        bus.i_tx_done   = 1'b1;
        @(negedge clk);
        bus.i_rx_done   = 1'b0;
        bus.i_tx_done   = 1'b0;
        check("coincident busy", bus.o_busy, 0);
        run_cmd("after coincident", 8'h06, 8'h03, 8'h22, 8'h03, 1'b0);
        finish_tx("after coincident");

        // Async reset mid-command discards the partial A byte
        send_byte(8'h09, ^8'h09);
        #2 rst = 1'b1;
        #1;
        check("midreset tx_data", bus.o_tx_data, 0);
        check("midreset parity", bus.o_tx_parity, 0);
        check("midreset busy", bus.o_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        run_cmd("post reset", 8'h02, 8'h03, 8'h24, 8'h02, 1'b0);
        finish_tx("post reset");

        // Parity fault on B
        send_byte(8'h05, ^8'h05);
        send_byte(8'h03, 1'b1);
`ifdef UART_INTF_PARITY_CHECK_EN
        check("parity err pulse", bus.o_error, 1);
        check("parity err busy", bus.o_busy, 0);
        send_byte(8'h03, 1'b0);
`else
        check("parity ignored", bus.o_error, 0);
`endif
        send_byte(8'h20, ^8'h20);
        check("parity cmd busy", bus.o_busy, 1);
        @(negedge clk);
        check("parity cmd strobe", bus.o_tx_signal, 1);
        check("parity cmd data", bus.o_tx_data, 8'h08);
        finish_tx("parity cmd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
